// File: rtl/mem_arbiter.sv
// Two-port arbiter (A = fetch, B = load/store) in front of a single data memory.
// Optional macro ARB_RR_EN: round-robin on simultaneous requests; otherwise B has fixed priority.
module mem_arbiter #(
    parameter int unsigned BUSY_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [1:0]  a_mem,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic [1:0]  b_mem,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic [1:0]  m_mem,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_busy,
    output logic        err
);

    localparam int unsigned CntW = $clog2(BUSY_LIMIT + 1);
    localparam logic [CntW-1:0] LimitC = CntW'(BUSY_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;  // 1 = port B
    logic [1:0]      mem_q, mem_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [CntW-1:0] wait_inc;
    logic            err_q, err_d;
    logic            grant_b;
`ifdef ARB_RR_EN
    logic            last_q, last_d;  // 1 = port B granted last
`endif

    assign wait_inc = wait_q + 1'b1;
    assign err      = err_q;

    always_comb begin
`ifdef ARB_RR_EN
        if (a_req && b_req) grant_b = ~last_q;
        else                grant_b = b_req;
`else
        grant_b = b_req;
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        mem_d   = mem_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        err_d   = err_q;
`ifdef ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (a_req || b_req) begin
                    owner_d = grant_b;
                    mem_d   = grant_b ? b_mem   : a_mem;
                    addr_d  = grant_b ? b_addr  : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
`ifdef ARB_RR_EN
                    last_d  = grant_b;
`endif
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!m_busy) begin
                    rdata_d = mem_q[0] ? m_rdata : '0;
                    wait_d  = '0;
                    state_d = StResp;
                end else if (wait_inc == LimitC) begin
                    // Memory stuck: abort and complete the owner with zero data.
                    err_d   = 1'b1;
                    rdata_d = '0;
                    wait_d  = '0;
                    state_d = StResp;
                end else begin
                    wait_d = wait_inc;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_mem   = '0;
        m_addr  = '0;
        m_wdata = '0;
        a_ack   = 1'b0;
        b_ack   = 1'b0;
        a_rdata = '0;
        b_rdata = '0;
        if (state_q == StIssue) begin
            m_mem   = mem_q;
            m_addr  = addr_q;
            m_wdata = wdata_q;
        end
        if (state_q == StResp) begin
            if (owner_q) begin
                b_ack   = 1'b1;
                b_rdata = rdata_q;
            end else begin
                a_ack   = 1'b1;
                a_rdata = rdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            mem_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            mem_q   <= mem_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
`ifdef ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter; expectations come from a transaction-level model.
// Works with or without ARB_RR_EN defined.
module tb_mem_arbiter;

    localparam int unsigned Limit = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0, a_ack, b_ack, m_busy = 1'b0, err;
    logic [1:0]  a_mem = '0, b_mem = '0, m_mem;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0, a_rdata, b_rdata;
    logic [31:0] m_addr, m_wdata, m_rdata = '0;

    int n_run = 0;
    int n_fail = 0;
    bit last_b = 1'b1;  // model: last granted port, B after reset
    bit err_m = 1'b0;   // model: sticky error

    // Observations from the most recent watch() call
    int          w_cycles;
    bit          w_got, w_b, w_stable, w_stray;
    logic [31:0] w_rd, w_addr, w_wdata;
    logic [1:0]  w_mem;

    always #5 clk = ~clk;

    mem_arbiter #(.BUSY_LIMIT(Limit)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_mem(a_mem), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_mem(b_mem), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .m_mem(m_mem), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_busy(m_busy), .err(err)
    );

    function automatic bit model_win_b(input bit ra, input bit rb);
        if (!ra) return 1'b1;
        if (!rb) return 1'b0;
`ifdef ARB_RR_EN
        return !last_b;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int model_len(input int nbusy);
        return (nbusy >= int'(Limit)) ? int'(Limit) : nbusy + 1;
    endfunction

    // Steps negedges until an ack (bounded); memory busy for the first nbusy issue cycles.
    task automatic watch(input int nbusy, input bit keep, input bit drop_early);
        w_got = 0; w_b = 0; w_rd = '0; w_cycles = 0; w_stable = 1; w_stray = 0;
        w_mem = '0; w_addr = '0; w_wdata = '0;
        for (int i = 1; i <= 20 && !w_got; i++) begin
            @(negedge clk);
            w_cycles = i;
            if (a_ack || b_ack) begin
                w_got = 1; w_b = b_ack; w_rd = b_ack ? b_rdata : a_rdata;
                if (a_ack && b_ack) w_stray = 1;
                if ((b_ack ? a_rdata : b_rdata) !== '0) w_stray = 1;
                if (m_mem !== 2'b00) w_stray = 1;
                if (!keep) begin a_req = 0; b_req = 0; end
            end else begin
                if (a_rdata !== '0 || b_rdata !== '0) w_stray = 1;
                if (i == 1) begin
                    w_mem = m_mem; w_addr = m_addr; w_wdata = m_wdata;
                end else if (m_mem !== w_mem || m_addr !== w_addr || m_wdata !== w_wdata) begin
                    w_stable = 0;
                end
                m_busy = (i <= nbusy);
                if (drop_early && i == 1) begin a_req = 0; b_req = 0; end
                a_mem = 2'($urandom); a_addr = $urandom; a_wdata = $urandom;
                b_mem = 2'($urandom); b_addr = $urandom; b_wdata = $urandom;
            end
        end
    endtask

    task automatic test_reset();
        a_req = 1; b_req = 1; a_mem = 2'b11; b_mem = 2'b11; m_busy = 0; rst_n = 0;
        repeat (2) @(negedge clk);
        n_run++;
        if ({a_ack, b_ack, m_mem, err} !== 5'b0 || a_rdata !== '0 || b_rdata !== '0
            || m_addr !== '0 || m_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: acks=%b%b m_mem=%b err=%b want all zero",
                     a_ack, b_ack, m_mem, err);
        end
        a_req = 0; b_req = 0; rst_n = 1; last_b = 1; err_m = 0;
        @(negedge clk);
        n_run++;
        if ({a_ack, b_ack, m_mem} !== 4'b0) begin
            n_fail++; $display("FAIL reset_idle: acks=%b%b m_mem=%b want 0", a_ack, b_ack, m_mem);
        end
    endtask

    task automatic test_read_a();
        a_req = 1; a_mem = 2'b01; a_addr = 0; a_wdata = 32'h1234; m_rdata = 1;
        watch(0, 0, 0);
        last_b = 0;
        n_run++;
        if (!w_got || w_b !== 1'b0 || w_cycles != 2) begin
            n_fail++;
            $display("FAIL read_a_ack: got=%0b portB=%0b cycles=%0d want 1 0 2", w_got, w_b, w_cycles);
        end
        n_run++;
        if (w_mem !== 2'b01 || w_addr !== 32'd0) begin
            n_fail++; $display("FAIL read_a_cmd: m_mem=%b m_addr=%h want 01 0", w_mem, w_addr);
        end
        n_run++;
        if (w_rd !== 32'd1 || w_stray) begin
            n_fail++; $display("FAIL read_a_rdata: rdata=%h stray=%0b want 1 0", w_rd, w_stray);
        end
        @(negedge clk);
        n_run++;
        if ({a_ack, b_ack} !== 2'b00) begin
            n_fail++; $display("FAIL read_a_pulse: acks=%b%b want 00", a_ack, b_ack);
        end
    endtask

    task automatic test_write_b_busy();
        b_req = 1; b_mem = 2'b10; b_addr = 5; b_wdata = 32'hDEADBEEF; m_rdata = 32'h5555AAAA;
        watch(3, 0, 0);
        last_b = 1;
        n_run++;
        if (!w_got || w_b !== 1'b1 || w_cycles != 5) begin
            n_fail++;
            $display("FAIL write_b_ack: got=%0b portB=%0b cycles=%0d want 1 1 5", w_got, w_b, w_cycles);
        end
        n_run++;
        if ({w_mem, w_addr, w_wdata} !== {2'b10, 32'd5, 32'hDEADBEEF} || !w_stable) begin
            n_fail++;
            $display("FAIL write_b_cmd: mem=%b addr=%h wdata=%h stable=%0b want 10 5 deadbeef 1",
                     w_mem, w_addr, w_wdata, w_stable);
        end
        n_run++;
        if (w_rd !== '0 || w_stray || err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_b_rdata: rdata=%h stray=%0b err=%b want 0 0 0", w_rd, w_stray, err);
        end
        @(negedge clk);
    endtask

    task automatic test_mem_corners();
        logic [1:0] cmds [2];
        cmds[0] = 2'b00; cmds[1] = 2'b11;
        for (int k = 0; k < 2; k++) begin
            a_req = 1; a_mem = cmds[k]; a_addr = 32'h40 + k; a_wdata = $urandom;
            m_rdata = 32'hCAFE0000 + k;
            watch(0, 0, 0);
            last_b = 0;
            n_run++;
            if (!w_got || w_b || w_mem !== cmds[k]
                || w_rd !== (cmds[k][0] ? 32'hCAFE0000 + k : 32'd0)) begin
                n_fail++;
                $display("FAIL mem_corner_%0d: got=%0b m_mem=%b rdata=%h want m_mem=%b",
                         k, w_got, w_mem, w_rd, cmds[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rv;
        a_req = 1; a_mem = 2'b01; a_addr = 32'h100; m_rdata = 32'hFFFF0000;
        watch(100, 0, 0);
        last_b = 0; err_m = 1;
        n_run++;
        if (!w_got || w_b || w_cycles != int'(Limit) + 1 || w_rd !== '0) begin
            n_fail++;
            $display("FAIL timeout_ack: got=%0b portB=%0b cycles=%0d rdata=%h want 1 0 %0d 0",
                     w_got, w_b, w_cycles, w_rd, Limit + 1);
        end
        n_run++;
        if (err !== err_m) begin
            n_fail++; $display("FAIL timeout_err: err=%b want %b", err, err_m);
        end
        @(negedge clk);
        rv = $urandom;
        b_req = 1; b_mem = 2'b01; b_addr = 32'h200; m_rdata = rv;
        watch(0, 0, 0);
        last_b = 1;
        n_run++;
        if (!w_got || !w_b || w_cycles != 2 || w_rd !== rv || err !== 1'b1) begin
            n_fail++;
            $display("FAIL after_timeout: got=%0b portB=%0b cycles=%0d rdata=%h err=%b want rdata %h err 1",
                     w_got, w_b, w_cycles, w_rd, err, rv);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        a_req = 1; a_mem = 2'b01; a_addr = 32'h300; m_busy = 1;
        @(negedge clk);
        n_run++;
        if (m_mem !== 2'b01 || err !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_pre: m_mem=%b err=%b want 01 1", m_mem, err);
        end
        rst_n = 0;
        @(negedge clk);
        n_run++;
        if ({m_mem, a_ack, b_ack, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid: m_mem=%b acks=%b%b err=%b want 0", m_mem, a_ack, b_ack, err);
        end
        a_req = 0; m_busy = 0; rst_n = 1; last_b = 1; err_m = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_run++;
            if ({a_ack, b_ack, m_mem} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_mid_drop_%0d: acks=%b%b m_mem=%b want 0", i, a_ack, b_ack, m_mem);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit exp_b;
        a_req = 1; b_req = 1; a_mem = 2'b01; b_mem = 2'b10; m_busy = 0;
        for (int t = 0; t < 4; t++) begin
            exp_b = model_win_b(1, 1);
            watch(0, t < 3, 0);
            last_b = exp_b;
            n_run++;
            if (!w_got || w_b !== exp_b || w_cycles != (t == 0 ? 2 : 3)) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got=%0b portB=%0b cycles=%0d want portB=%0b cycles=%0d",
                         t, w_got, w_b, w_cycles, exp_b, t == 0 ? 2 : 3);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        a_req = 1; a_mem = 2'b10; a_addr = 32'h77;
        watch(2, 0, 1);
        last_b = 0;
        n_run++;
        if (!w_got || w_b || w_cycles != 4 || w_mem !== 2'b10 || !w_stable) begin
            n_fail++;
            $display("FAIL drop_req: got=%0b portB=%0b cycles=%0d mem=%b stable=%0b want 1 0 4 10 1",
                     w_got, w_b, w_cycles, w_mem, w_stable);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int          pat, nb, exp_len;
        bit          exp_b, to;
        logic [1:0]  am, bm, em;
        logic [31:0] aa, ad, ba, bd, ea, ed, rv, exp_rd;
        for (int t = 0; t < 40; t++) begin
            pat = $urandom_range(1, 3); nb = $urandom_range(0, 5);
            am = 2'($urandom); bm = 2'($urandom); rv = $urandom;
            aa = $urandom; ad = $urandom; ba = $urandom; bd = $urandom;
            exp_b = model_win_b(pat[0], pat[1]);
            em = exp_b ? bm : am; ea = exp_b ? ba : aa; ed = exp_b ? bd : ad;
            to = (nb >= int'(Limit));
            exp_len = model_len(nb);
            exp_rd = (to || !em[0]) ? 32'd0 : rv;
            a_req = pat[0]; b_req = pat[1]; a_mem = am; a_addr = aa; a_wdata = ad;
            b_mem = bm; b_addr = ba; b_wdata = bd; m_rdata = rv;
            watch(nb, 0, 0);
            last_b = exp_b;
            err_m = err_m | to;
            n_run++;
            if (!w_got || w_b !== exp_b || w_cycles != exp_len + 1 || w_rd !== exp_rd || w_stray) begin
                n_fail++;
                $display("FAIL rand_%0d_resp: got=%0b portB=%0b cycles=%0d rdata=%h stray=%0b want portB=%0b cycles=%0d rdata=%h",
                         t, w_got, w_b, w_cycles, w_rd, w_stray, exp_b, exp_len + 1, exp_rd);
            end
            n_run++;
            if ({w_mem, w_addr, w_wdata} !== {em, ea, ed} || !w_stable || err !== err_m) begin
                n_fail++;
                $display("FAIL rand_%0d_cmd: mem=%b addr=%h wdata=%h stable=%0b err=%b want %b %h %h 1 %b",
                         t, w_mem, w_addr, w_wdata, w_stable, err, em, ea, ed, err_m);
            end
            @(negedge clk);
            n_run++;
            if ({a_ack, b_ack} !== 2'b00) begin
                n_fail++; $display("FAIL rand_%0d_pulse: acks=%b%b want 00", t, a_ack, b_ack);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_a();
        test_write_b_busy();
        test_mem_corners();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_drop_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BUSY_LIMIT, default 255: maximum number of cycles m_busy may hold one transaction before it is aborted.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 a_req  input  1  port A (fetch) request; held high until a_ack.
REQ-005 a_mem  input  2  port A command; bit0 = read, bit1 = write.
REQ-006 a_addr, a_wdata  input  32 each  port A address and write data.
REQ-007 a_ack  output  1  port A completion pulse.
REQ-008 a_rdata  output  32  port A read data; valid while a_ack is high.
REQ-009 b_req, b_mem, b_addr, b_wdata, b_ack, b_rdata: port B (load/store), same widths and meaning as port A.
REQ-010 m_mem  output  2  command to data memory.
REQ-011 m_addr, m_wdata  output  32 each  address and write data to data memory.
REQ-012 m_rdata  input  32  read data from data memory.
REQ-013 m_busy  input  1  data memory not ready; the command must be held.
REQ-014 err  output  1  sticky flag: a transaction was aborted on timeout.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE and RESP.
REQ-016 IDLE: if any req is high, the arbiter SHALL select one port, latch its mem/addr/wdata and the owner ID into registers, and go to ISSUE; otherwise it stays in IDLE.
REQ-017 ISSUE: m_mem/m_addr/m_wdata SHALL come from the latched registers, held stable regardless of requester inputs.
REQ-018 ISSUE with m_busy=0: rdata register SHALL capture m_rdata if latched mem[0]=1, else 0; wait counter clears; go to RESP.
REQ-019 ISSUE with m_busy=1: wait counter increments; on the cycle the counter equals BUSY_LIMIT, err is set, rdata register is 0, go to RESP.
REQ-020 RESP: the owner's ack SHALL be high for exactly one cycle, with that port's rdata equal to the rdata register; m_mem=00; go to IDLE.
REQ-021 Outside RESP, both acks SHALL be 0 and both rdata outputs 0; m_mem=00 in every state except ISSUE.
REQ-022 Latency with m_busy=0: request seen in IDLE at edge k gives ISSUE in cycle k+1 and ack in cycle k+2; the minimum back-to-back rate is one transaction per 3 cycles.
REQ-023 Latched mem=00 SHALL complete through ISSUE with m_mem=00 and rdata 0.
REQ-024 Latched mem=11 SHALL drive m_mem=11 (read and write in the same cycle); the captured rdata is the pre-write memory value.
REQ-025 A requester dropping req before ack SHALL NOT cancel the transaction; the ack is still issued.
REQ-026 A requester whose req is still high in IDLE after its ack is treated as a new request.
REQ-027 The err flag is cleared only by reset.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force: state IDLE, all outputs 0, err 0, wait counter 0, last-grant register = B; this applies mid-transaction, and the pending transaction is dropped without ack.

Configuration
REQ-029 With ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted to the port not granted last; last-grant updates on every grant.
REQ-030 Without ARB_RR_EN, port B SHALL always win simultaneous requests (fixed priority); the last-grant register is absent.

Verification
REQ-031 Port A read, addr=0, m_busy=0, m_rdata=1 -> m_mem=01 in cycle k+1; a_ack=1 and a_rdata=1 in cycle k+2; b_ack stays 0.
REQ-032 Port B write, addr=5, wdata=0xDEADBEEF, m_busy high 3 cycles -> m_mem=10, m_addr=5, m_wdata=0xDEADBEEF held 4 cycles; b_ack one cycle later.
REQ-033 a_req and b_req both high continuously, ARB_RR_EN defined -> grants A, B, A, B after reset; without the macro -> B every time.
REQ-034 BUSY_LIMIT=4, m_busy stuck 1 -> after 4 ISSUE wait cycles the owner is acked with rdata 0, err=1, and a subsequent request proceeds normally.
REQ-035 rst_n=0 asserted during ISSUE -> next cycle state IDLE, m_mem=00, no ack, err=0.
